// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, refill FSM state enum and line-base helper
package cache_pkg;
    localparam int LINE_W        = 1024;
    localparam int MEM_W         = 32;
    localparam int ADDR_W        = 32;
    localparam int BEATS         = LINE_W / MEM_W;
    localparam int LINE_OFF_BITS = $clog2(LINE_W / 8);
    localparam int BYTE_OFF_BITS = $clog2(MEM_W / 8);
    localparam int CNT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RD,
        DONE
    } refill_state_t;

    // Clears the byte offset within a cache line.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & ~((ADDR_W'(1) << LINE_OFF_BITS) - ADDR_W'(1));
    endfunction
endpackage

// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - narrow request/acknowledge memory bus
// master: controller (drives mem_req, mem_we, mem_addr, mem_wdata)
// slave : memory     (drives mem_rdata, mem_ack)
interface cache_refill_ctrl_if;
    import cache_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/refill_line_buf.sv
// rtl/refill_line_buf.sv - BEATS x MEM_W line buffer with beat and full-line access
// load_en/load_line : parallel load of a whole line (has priority over beat write)
// wr_en/wr_idx/wr_data : single beat write
// rd_idx/rd_data : single beat read
// line_out : whole line read
module refill_line_buf
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              load_en,
    input  logic [LINE_W-1:0] load_line,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [MEM_W-1:0]  wr_data,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [MEM_W-1:0]  rd_data,
    output logic [LINE_W-1:0] line_out
);
    logic [MEM_W-1:0] beat_q [BEATS];
    logic [MEM_W-1:0] beat_d [BEATS];

    always_comb begin
        for (int k = 0; k < BEATS; k++) begin
            beat_d[k] = beat_q[k];
            if (load_en) begin
                beat_d[k] = load_line[k*MEM_W +: MEM_W];
            end else if (wr_en && (wr_idx == CNT_W'(k))) begin
                beat_d[k] = wr_data;
            end
        end
    end

    // Pure datapath storage: contents are only observed after a load or write.
    always_ff @(posedge clk) begin
        beat_q <= beat_d;
    end

    assign rd_data = beat_q[rd_idx];

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line_out[g*MEM_W +: MEM_W] = beat_q[g];
    end
endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - dirty-line writeback and line refill controller
// clk, rst (sync, active-high)
// miss_req/miss_addr, evict_dirty/evict_addr/evict_line : miss request from the cache
// fill_line/fill_valid : refilled line back to the cache; busy : FSM not idle
// mem : narrow memory bus (master side)
// Option: CACHE_REFILL_CRIT_FIRST_EN starts the read burst at the missing word.
module cache_refill_ctrl
    import cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_req,
    input  logic [ADDR_W-1:0]          miss_addr,
    input  logic                       evict_dirty,
    input  logic [ADDR_W-1:0]          evict_addr,
    input  logic [LINE_W-1:0]          evict_line,
    output logic [LINE_W-1:0]          fill_line,
    output logic                       fill_valid,
    output logic                       busy,
    cache_refill_ctrl_if.master        mem
);
    refill_state_t     state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  start_q, start_d;
    logic [ADDR_W-1:0] miss_base_q, miss_base_d;
    logic [ADDR_W-1:0] evict_base_q, evict_base_d;
    logic [LINE_W-1:0] fill_line_q, fill_line_d;
    logic [CNT_W-1:0]  next_beat, crit_idx;
    logic [ADDR_W-1:0] beat_off;
    logic [LINE_W-1:0] buf_line;
    logic [MEM_W-1:0]  buf_rd_data;
    logic              buf_load, buf_wr;

`ifdef CACHE_REFILL_CRIT_FIRST_EN
    assign crit_idx = CNT_W'(miss_addr[LINE_OFF_BITS-1:BYTE_OFF_BITS]);
`else
    assign crit_idx = '0;
`endif

    assign next_beat = (beat_q == CNT_W'(BEATS - 1)) ? '0 : beat_q + 1'b1;
    assign beat_off  = ADDR_W'(beat_q) << BYTE_OFF_BITS;

    // One buffer serves both phases: the victim snapshot is fully drained in WB
    // before RD starts overwriting beats with fetched data.
    refill_line_buf u_buf (
        .clk       (clk),
        .load_en   (buf_load),
        .load_line (evict_line),
        .wr_en     (buf_wr),
        .wr_idx    (beat_q),
        .wr_data   (mem.mem_rdata),
        .rd_idx    (beat_q),
        .rd_data   (buf_rd_data),
        .line_out  (buf_line)
    );

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        start_d       = start_q;
        miss_base_d   = miss_base_q;
        evict_base_d  = evict_base_q;
        fill_line_d   = fill_line_q;
        buf_load      = 1'b0;
        buf_wr        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (miss_req) begin
                    miss_base_d  = line_base(miss_addr);
                    evict_base_d = line_base(evict_addr);
                    start_d      = crit_idx;
                    buf_load     = evict_dirty;
                    if (evict_dirty) begin
                        state_d = WB;
                        beat_d  = '0;
                    end else begin
                        state_d = RD;
                        beat_d  = crit_idx;
                    end
                end
            end
            WB: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = evict_base_q + beat_off;
                mem.mem_wdata = buf_rd_data;
                if (mem.mem_ack) begin
                    if (beat_q == CNT_W'(BEATS - 1)) begin
                        state_d = RD;
                        beat_d  = start_q;
                    end else begin
                        beat_d = next_beat;
                    end
                end
            end
            RD: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = miss_base_q + beat_off;
                if (mem.mem_ack) begin
                    buf_wr = 1'b1;
                    beat_d = next_beat;
                    // The burst ends when the wrapped counter returns to its start.
                    // The last beat is merged here so fill_line is complete in DONE
                    // while the register holds the previous fill until then.
                    if (next_beat == start_q) begin
                        state_d     = DONE;
                        fill_line_d = buf_line;
                        fill_line_d[beat_q*MEM_W +: MEM_W] = mem.mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            start_q      <= '0;
            miss_base_q  <= '0;
            evict_base_q <= '0;
            fill_line_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            start_q      <= start_d;
            miss_base_q  <= miss_base_d;
            evict_base_q <= evict_base_d;
            fill_line_q  <= fill_line_d;
        end
    end

    assign fill_line  = fill_line_q;
    assign fill_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
endmodule
